// File: rtl/pe_interco_pkg.sv
// Shared types and constants for the peripheral interconnect response path.
// Holds the tracker FSM states, opcode encodings and the default timeout data word.
package pe_interco_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StPending,
        StFull
    } trk_state_e;

    localparam logic OPC_OK  = 1'b0;
    localparam logic OPC_ERR = 1'b1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADC_AB1E;

endpackage

// File: rtl/pe_id_fifo.sv
// In-order FIFO of slave IDs for outstanding requests.
// Pointers wrap naturally because DEPTH is a power of two.
module pe_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_id;
    end

endmodule

// File: rtl/pe_resp_tracker.sv
// Matches merged peripheral responses to outstanding requests and tags them with the slave ID.
// Optional head-of-line response timeout is enabled with macro PE_RESP_TIMEOUT_EN.
module pe_resp_tracker
    import pe_interco_pkg::*;
#(
    parameter int unsigned  N_SLAVE        = 16,
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  DEPTH          = 4,
    parameter int unsigned  TIMEOUT_CYCLES = 256,
    parameter logic [31:0]  ERR_DATA       = ERR_DATA_DEFAULT,
    localparam int unsigned LOG_SLAVE      = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1,
    localparam int unsigned CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_push_i,
    input  logic [LOG_SLAVE-1:0]  req_dest_i,
    output logic                  req_ready_o,
    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic                  data_r_opc_i,
    output logic                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_opc_o,
    output logic [LOG_SLAVE-1:0]  data_r_dest_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  spurious_o,
    output logic                  overflow_o,
    output logic                  timeout_o
);

    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_DATA);

    trk_state_e state_q, state_d;

    logic                 push_acc, pop, tmo_hit, has_entries;
    logic                 fifo_full, fifo_empty;
    logic [LOG_SLAVE-1:0] head_id;
    logic [CNT_W-1:0]     fifo_count, cnt_next;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  opc_q, opc_d;
    logic [LOG_SLAVE-1:0]  dest_q, dest_d;
    logic                  spurious_q, spurious_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_q, timeout_d;

    assign has_entries = (state_q != StEmpty);
    assign req_ready_o = (state_q != StFull);
    assign push_acc    = req_push_i && req_ready_o;
    assign pop         = (data_r_valid_i || tmo_hit) && has_entries;

    pe_id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LOG_SLAVE)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_acc),
        .push_id (req_dest_i),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef PE_RESP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q;

    // A real response in the same cycle wins; the counter then restarts for the next head.
    assign tmo_hit = has_entries && !data_r_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (!has_entries || pop) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= StEmpty;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_next   = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);
        valid_d    = pop;
        rdata_d    = '0;
        opc_d      = OPC_OK;
        dest_d     = '0;
        spurious_d = data_r_valid_i && !has_entries;
        overflow_d = req_push_i && !req_ready_o;
        timeout_d  = tmo_hit && has_entries;

        if (pop) begin
            rdata_d = data_r_valid_i ? data_r_rdata_i : ERR_RDATA;
            opc_d   = data_r_valid_i ? data_r_opc_i : OPC_ERR;
            dest_d  = head_id;
        end

        unique case (state_q)
            StEmpty: begin
                if (push_acc) state_d = StPending;
            end
            StPending: begin
                if (cnt_next == CNT_W'(DEPTH)) state_d = StFull;
                else if (cnt_next == '0)       state_d = StEmpty;
            end
            StFull: begin
                if (pop) state_d = StPending;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            opc_q      <= 1'b0;
            dest_q     <= '0;
            spurious_q <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            opc_q      <= opc_d;
            dest_q     <= dest_d;
            spurious_q <= spurious_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign data_r_valid_o = valid_q;
    assign data_r_rdata_o = rdata_q;
    assign data_r_opc_o   = opc_q;
    assign data_r_dest_o  = dest_q;
    assign outstanding_o  = fifo_count;
    assign spurious_o     = spurious_q;
    assign overflow_o     = overflow_q;
    assign timeout_o      = timeout_q;

    // The FSM and the FIFO occupancy must never disagree.
    assert property (@(posedge clk) disable iff (rst) (state_q == StFull) == fifo_full);
    assert property (@(posedge clk) disable iff (rst) (state_q == StEmpty) == fifo_empty);

endmodule

// File: tb/tb_pe_resp_tracker.sv
// Randomised and directed bench for pe_resp_tracker against a queue-based reference model.
// Timeout scenarios run only when PE_RESP_TIMEOUT_EN is defined.
module tb_pe_resp_tracker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;
`ifdef PE_RESP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        opc;
        logic [3:0]  dest;
        logic [2:0]  outst;
        logic        spur;
        logic        ovf;
        logic        tmo;
        logic        ready;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_push_i = 1'b0;
    logic [3:0]  req_dest_i = '0;
    logic        req_ready_o;
    logic        data_r_valid_i = 1'b0;
    logic [31:0] data_r_rdata_i = '0;
    logic        data_r_opc_i = 1'b0;
    logic        data_r_valid_o;
    logic [31:0] data_r_rdata_o;
    logic        data_r_opc_o;
    logic [3:0]  data_r_dest_o;
    logic [2:0]  outstanding_o;
    logic        spurious_o, overflow_o, timeout_o;

    int checks = 0;
    int failures = 0;

    logic [3:0] mq[$];
    int         age = 0;

    always #5 clk = ~clk;

    pe_resp_tracker #(
        .N_SLAVE        (16),
        .DATA_WIDTH     (32),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (32'hBADC_AB1E)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_push_i     (req_push_i),
        .req_dest_i     (req_dest_i),
        .req_ready_o    (req_ready_o),
        .data_r_valid_i (data_r_valid_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_opc_i   (data_r_opc_i),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_r_dest_o  (data_r_dest_o),
        .outstanding_o  (outstanding_o),
        .spurious_o     (spurious_o),
        .overflow_o     (overflow_o),
        .timeout_o      (timeout_o)
    );

    // Reference: a queue of pending IDs plus the age of the current head.
    function automatic obs_t model_step(logic push, logic [3:0] dest, logic valid,
                                        logic [31:0] rdata, logic opc);
        obs_t e = '0;
        int   n;
        if (rst) begin
            mq.delete();
            age = 0;
            e.ready = 1'b1;
            return e;
        end
        n = mq.size();
        if (valid && n > 0) begin
            e.valid = 1'b1; e.rdata = rdata; e.opc = opc; e.dest = mq.pop_front();
            age = 0;
        end else if (valid) begin
            e.spur = 1'b1;
        end else if (TMO_EN && n > 0 && age == TMO - 1) begin
            e.valid = 1'b1; e.rdata = 32'hBADC_AB1E; e.opc = 1'b1; e.dest = mq.pop_front();
            e.tmo = 1'b1;
            age = 0;
        end else if (n > 0) begin
            age++;
        end
        if (push) begin
            if (n == DEPTH) e.ovf = 1'b1;
            else            mq.push_back(dest);
        end
        if (mq.size() == 0) age = 0;
        e.outst = 3'(mq.size());
        e.ready = (mq.size() != DEPTH);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.valid = data_r_valid_o;
        o.rdata = data_r_valid_o ? data_r_rdata_o : '0;
        o.opc   = data_r_valid_o ? data_r_opc_o : 1'b0;
        o.dest  = data_r_valid_o ? data_r_dest_o : '0;
        o.outst = outstanding_o;
        o.spur  = spurious_o;
        o.ovf   = overflow_o;
        o.tmo   = timeout_o;
        o.ready = req_ready_o;
        return o;
    endfunction

    task automatic step(input logic push, input logic [3:0] dest, input logic valid,
                        input logic [31:0] rdata, input logic opc,
                        output obs_t exp, output obs_t got);
        req_push_i     = push;
        req_dest_i     = dest;
        data_r_valid_i = valid;
        data_r_rdata_i = rdata;
        data_r_opc_i   = opc;
        exp = model_step(push, dest, valid, rdata, opc);
        @(posedge clk);
        #1;
        got = sample();
    endtask

    task automatic test_reset();
        obs_t exp, got;
        rst = 1'b1;
        step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
        rst = 1'b0;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", got, exp);
        end
        checks++;
        if (got.ready !== 1'b1 || got.outst !== 3'd0) begin
            failures++;
            $display("FAIL reset_ready got ready=%b outst=%0d want 1/0", got.ready, got.outst);
        end
    endtask

    task automatic test_single();
        obs_t exp, got;
        logic [2:0] kind [4] = '{3'b100, 3'b000, 3'b000, 3'b010};
        for (int i = 0; i < 4; i++) begin
            step(kind[i][2], 4'd5, kind[i][1], 32'h1234_5678, 1'b0, exp, got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (got.valid !== 1'b1 || got.rdata !== 32'h1234_5678 || got.dest !== 4'd5 ||
            got.outst !== 3'd0) begin
            failures++;
            $display("FAIL single_resp got v=%b d=%h dest=%0d outst=%0d want 1/12345678/5/0",
                     got.valid, got.rdata, got.dest, got.outst);
        end
        step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
        checks++;
        if (got.valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got valid=%b want 0", got.valid);
        end
    endtask

    task automatic test_fill_overflow();
        obs_t exp, got;
        logic [3:0] ids [5] = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd2};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ids[i], 1'b0, 32'd0, 1'b0, exp, got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp);
            end
            if (i == 3) begin
                checks++;
                if (got.ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_ready got=%b want 0", got.ready);
                end
            end
        end
        checks++;
        if (got.ovf !== 1'b1 || got.outst !== 3'd4) begin
            failures++;
            $display("FAIL overflow got ovf=%b outst=%0d want 1/4", got.ovf, got.outst);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 1'b1, $urandom, 1'($urandom), exp, got);
            checks++;
            if (got !== exp || got.dest !== ids[i]) begin
                failures++;
                $display("FAIL drain[%0d] got=%h exp=%h want dest=%0d", i, got, exp, ids[i]);
            end
        end
    endtask

    task automatic test_spurious();
        obs_t exp, got;
        step(1'b0, 4'd0, 1'b1, 32'hDEAD_0001, 1'b0, exp, got);
        checks++;
        if (got !== exp || got.valid !== 1'b0 || got.spur !== 1'b1 || got.outst !== 3'd0) begin
            failures++;
            $display("FAIL spurious got=%h exp=%h", got, exp);
        end
        // Push and response together while empty: response is spurious, push is kept.
        step(1'b1, 4'd11, 1'b1, 32'hDEAD_0002, 1'b0, exp, got);
        checks++;
        if (got !== exp || got.spur !== 1'b1 || got.outst !== 3'd1) begin
            failures++;
            $display("FAIL spur_push got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp, got;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(i + 1), 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, exp, got);
            checks++;
            if (got !== exp || got.outst !== 3'd1) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        step(1'b0, 4'd0, 1'b1, 32'h0, 1'b1, exp, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_drain got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_timeout();
        obs_t exp, got;
        if (TMO_EN) begin
            step(1'b1, 4'd4, 1'b0, 32'd0, 1'b0, exp, got);
            for (int i = 0; i < TMO; i++) begin
                step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL tmo[%0d] got=%h exp=%h", i, got, exp);
                end
            end
            checks++;
            if (got.valid !== 1'b1 || got.opc !== 1'b1 || got.rdata !== 32'hBADC_AB1E ||
                got.dest !== 4'd4 || got.tmo !== 1'b1) begin
                failures++;
                $display("FAIL tmo_fire got=%h want valid/opc/BADCAB1E/dest4/tmo", got);
            end
            // Real response on the expiry cycle wins over the timeout.
            step(1'b1, 4'd6, 1'b0, 32'd0, 1'b0, exp, got);
            step(1'b1, 4'd8, 1'b0, 32'd0, 1'b0, exp, got);
            for (int i = 0; i < TMO - 2; i++) step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
            step(1'b0, 4'd0, 1'b1, 32'h5555_AAAA, 1'b0, exp, got);
            checks++;
            if (got !== exp || got.tmo !== 1'b0 || got.rdata !== 32'h5555_AAAA ||
                got.dest !== 4'd6) begin
                failures++;
                $display("FAIL tmo_prio got=%h exp=%h", got, exp);
            end
            for (int i = 0; i < TMO; i++) begin
                step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL tmo_restart[%0d] got=%h exp=%h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t exp, got;
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 12), 1'b0, 32'd0, 1'b0, exp, got);
        rst = 1'b1;
        step(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, exp, got);
        rst = 1'b0;
        checks++;
        if (got !== exp || got.outst !== 3'd0 || got.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", got, exp);
        end
        step(1'b0, 4'd0, 1'b1, 32'h0BAD_F00D, 1'b0, exp, got);
        checks++;
        if (got !== exp || got.spur !== 1'b1 || got.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_spur got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random();
        obs_t exp, got;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0), $urandom, 1'($urandom), exp, got);
            rst = 1'b0;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_spurious();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_resp_tracker.md
PE_RESP_TRACKER -- requirements
Module: pe_resp_tracker

Interface
REQ-001 SHALL have parameter N_SLAVE, default 16, number of peripheral slaves behind the response tree.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, response data width.
REQ-003 SHALL have parameter DEPTH, default 4, maximum outstanding requests (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, response timeout limit.
REQ-005 SHALL have parameter ERR_DATA, default 32'hBADC_AB1E, rdata returned on timeout (truncated to DATA_WIDTH).
REQ-006 SHALL have ports (LOG_SLAVE = clog2(N_SLAVE); one clock; reset is synchronous and active-high):
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  req_push_i  in  1  request accepted by slave side (req & gnt) this cycle
  req_dest_i  in  LOG_SLAVE  slave index of accepted request
  req_ready_o  out  1  tracker can record another request (not full)
  data_r_valid_i  in  1  merged response valid from response tree
  data_r_rdata_i  in  DATA_WIDTH  merged response data
  data_r_opc_i  in  1  merged response error/opcode bit
  data_r_valid_o  out  1  registered response valid to master
  data_r_rdata_o  out  DATA_WIDTH  registered response data
  data_r_opc_o  out  1  registered opcode (1 = error)
  data_r_dest_o  out  LOG_SLAVE  slave index the response belongs to
  outstanding_o  out  clog2(DEPTH)+1  current outstanding count
  spurious_o  out  1  one-cycle pulse: response with nothing outstanding
  overflow_o  out  1  one-cycle pulse: push while full (push dropped)
  timeout_o  out  1  one-cycle pulse: head request timed out

Function
REQ-007 SHALL record req_dest_i in an in-order ID FIFO when req_push_i && req_ready_o.
REQ-008 SHALL pop FIFO head on data_r_valid_i when non-empty; outputs next cycle: valid=1, rdata/opc from inputs, dest=head ID (latency 1).
REQ-009 SHALL, on data_r_valid_i while empty, drop response (data_r_valid_o=0) and pulse spurious_o next cycle.
REQ-010 SHALL drive req_ready_o = (state != FULL), combinationally from registered state.
REQ-011 SHALL, on req_push_i while FULL, drop push, pulse overflow_o next cycle, leave FIFO unchanged.
REQ-012 SHALL on simultaneous push and pop when non-empty and not full keep count unchanged, pop old head, append new ID.
REQ-013 SHALL on simultaneous push and valid while empty treat response as spurious and record the push (count becomes 1).
REQ-014 SHALL implement FSM EMPTY / PENDING / FULL: EMPTY->PENDING on push; PENDING->FULL when count reaches DEPTH; FULL->PENDING on pop; PENDING->EMPTY when count reaches 0.
REQ-015 SHALL keep outstanding_o equal to FIFO occupancy, 0..DEPTH, with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL pulse data_r_valid_o exactly one cycle per accepted response; all pulse outputs 0 otherwise.

Reset
REQ-017 SHALL on rst=1 at a clock edge set state EMPTY, pointers/count 0, timeout counter 0, and all outputs 0 (req_ready_o=1).
REQ-018 SHALL discard all outstanding entries on reset mid-operation; responses arriving after reset are spurious.

Configuration
REQ-019 SHALL, with macro PE_RESP_TIMEOUT_EN defined, count cycles while non-empty, clear counter on every pop or transition into PENDING from EMPTY, and on reaching TIMEOUT_CYCLES-1 pop head, emit data_r_valid_o=1, opc=1, rdata=ERR_DATA, dest=head ID, and pulse timeout_o.
REQ-020 SHALL give a real response priority over a timeout in the same cycle (counter cleared, no timeout_o).
REQ-021 SHALL, without PE_RESP_TIMEOUT_EN, omit the counter entirely and tie timeout_o to 0.

Structure
REQ-022 SHALL place FSM state enum, opcode constants (OPC_OK=0, OPC_ERR=1) and default ERR_DATA in shared package pe_interco_pkg.
REQ-023 SHALL instantiate one sub-module pe_id_fifo (DEPTH x LOG_SLAVE storage, push/pop/full/empty/count).

Verification
REQ-024 Push dest=5, response rdata=32'h1234_5678 opc=0 two cycles later -> next cycle valid=1, rdata=32'h1234_5678, dest=5, outstanding 1->0.
REQ-025 Push 3,7,1,9 (DEPTH=4) -> req_ready_o=0; 5th push dest=2 -> overflow_o pulse; four responses return dests 3,7,1,9 in order.
REQ-026 Response while empty -> no data_r_valid_o, spurious_o pulse, outstanding stays 0.
REQ-027 With PE_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, push dest=4, no response -> after 8 cycles valid=1, opc=1, rdata=32'hBADC_AB1E, dest=4, timeout_o=1.
REQ-028 Response and timeout expiry in same cycle -> real data returned, timeout_o=0, counter restarted for next head.
REQ-029 Push 3 entries, assert rst one cycle -> outstanding_o=0, req_ready_o=1; subsequent response flagged spurious.
